read_counters: RTL
==================

// Module: read_counters
// PURPOSE
//  Read-path timing sequencer for the DDR5 PHY read manager; the read-side counterpart of the write counters.
//  Takes one-cycle read requests from the MC (DFI rddata_en pulse) and sequences DQS gate, data capture,
//  CRC check and postamble windows. It also merges back-to-back reads into a continuous gate (interamble).
//  Sits between the DFI read interface and the DQ/DQS receiver capture logic.
// PARAMETERS
//  BL16_CYCLES  8  clock cycles of data for BL16 (i_burstlength=2'b00)
//  BL8_CYCLES   4  clock cycles of data for BL8 chop (i_burstlength=2'b01)
//  CNT_W        4  width of internal counters and o_beat_cnt
// PORTS
//  i_clk          in   1      system clock
//  i_rst          in   1      asynchronous active-low reset
//  i_rd_en        in   1      read request pulse; one pulse per burst
//  i_precycle     in   3      read preamble length in cycles; 0 treated as 1, values >4 clamped to 4
//  i_postcycle    in   2      read postamble length in cycles, 0..3
//  i_burstlength  in   2      00=BL16, 01=BL8; 1x treated as BL16
//  i_dram_crc_en  in   1      DRAM appends one CRC cycle after data
//  o_state        out  3      000 IDLE, 001 PREAMBLE, 010 RDDATA, 011 POSTAMBLE, 100 INTERAMBLE, 111 RDCRC
//  o_dqs_gate     out  1      DQS receiver gate; high in every state except IDLE
//  o_capture_en   out  1      data capture strobe; high in RDDATA only
//  o_beat_cnt     out  CNT_W  data cycle index within RDDATA (0..N-1), 0 elsewhere
//  o_burst_done   out  1      high for one cycle: last RDDATA cycle, or the RDCRC cycle when CRC is active
//  o_crc_check    out  1      high in RDCRC; tells the CRC checker to compare the captured CRC
//  o_overflow     out  1      sticky; a request arrived while one was already pending
// BEHAVIOUR
//  - Reset (async, i_rst=0): state IDLE; all outputs and counters 0; pending flag and config cleared.
//  - All outputs are decoded from registered state/counters. No combinational path from any input to any output.
//  - IDLE: i_rd_en=1 at edge N -> PREAMBLE from N+1. Config inputs are latched at this edge.
//  - PREAMBLE: lasts P=clamp(i_precycle) cycles -> RDDATA.
//  - RDDATA: lasts N=BL16_CYCLES or BL8_CYCLES; o_beat_cnt counts 0..N-1. Next state:
//    RDCRC if the latched crc_en is set; else INTERAMBLE if a request is pending; else POSTAMBLE
//    (IDLE directly if postcycle=0).
//  - RDCRC: lasts 1 cycle; then the same pending/postamble decision as at the end of RDDATA.
//  - INTERAMBLE: lasts P cycles with the gate held high; clears pending; relatches config -> RDDATA.
//  - POSTAMBLE: lasts i_postcycle cycles -> IDLE. A request arriving here is pending; it goes to
//    PREAMBLE once IDLE is reached.
//  - Pending: i_rd_en=1 in any non-IDLE state sets a one-deep pending flag. This includes the last
//    data/CRC cycle; in that case the next state is INTERAMBLE.
//  - If i_rd_en=1 while pending is already set, the request is dropped and o_overflow is set
//    (sticky until reset).
//  - Config changes during a burst are ignored until the next latch point.
//  - Counters saturate/clear on state change; no wrap occurs within a state.
//  - Reset mid-burst: outputs drop to 0 asynchronously; no partial burst resumes.
// CONFIGURATION
//  - RD_CRC_CHECK_EN defined: RDCRC state exists as above.
//  - RD_CRC_CHECK_EN undefined: i_dram_crc_en is ignored; RDCRC is never entered; o_crc_check is tied 0;
//    o_burst_done is always on the last RDDATA cycle.
// TESTING
//  1 BL16, pre=2, post=1, crc=0, i_rd_en pulse at cycle 0 -> gate 1..11, capture 3..10,
//    beat 0..7 on 3..10, burst_done@10, IDLE@12.
//  2 As test 1 with crc=1 (macro on) -> capture 3..10, crc_check@11, burst_done@11, post@12,
//    gate 1..12; with macro off, same as test 1.
//  3 BL8, pre=1, post=1, pulses at 0 and 3 -> pre@1, data 2..5, interamble@6, data 7..10,
//    post@11, gate continuously high 1..11.
//  4 Pulses at 0, 1, 2 (BL16) -> one pending, third request dropped, o_overflow=1 from cycle 3 and held.
//  5 i_precycle=0 and i_precycle=6 -> preamble of 1 and 4 cycles respectively; postcycle=0
//    -> IDLE directly after data.
//  6 Assert i_rst=0 mid-RDDATA -> all outputs 0 immediately; next pulse after release runs a clean burst.

Source files
------------

// File: rtl/read_counters.sv
// Read-path timing sequencer: DQS gate, data capture, optional CRC and postamble windows.
// Optional RDCRC state is built when the macro RD_CRC_CHECK_EN is defined.
module read_counters #(
   parameter int BL16_CYCLES = 8,
   parameter int BL8_CYCLES  = 4,
   parameter int CNT_W       = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_rd_en,
   input  logic [2:0]       i_precycle,
   input  logic [1:0]       i_postcycle,
   input  logic [1:0]       i_burstlength,
   input  logic             i_dram_crc_en,
   output logic [2:0]       o_state,
   output logic             o_dqs_gate,
   output logic             o_capture_en,
   output logic [CNT_W-1:0] o_beat_cnt,
   output logic             o_burst_done,
   output logic             o_crc_check,
   output logic             o_overflow
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_PRE   = 3'b001,
      S_DATA  = 3'b010,
      S_POST  = 3'b011,
      S_INTER = 3'b100,
      S_CRC   = 3'b111
   } state_t;

`ifdef RD_CRC_CHECK_EN
   localparam logic CRC_ON = 1'b1;
`else
   localparam logic CRC_ON = 1'b0;
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pending;
   logic             overflow;
   logic [2:0]       pre_q;
   logic [1:0]       post_q;
   logic [CNT_W-1:0] len_q;
   logic             crc_q;

   logic [CNT_W-1:0] last_cnt;
   logic             state_last;
   logic             start;
   logic             burst_end;
   logic             take_inter;
   state_t           after_state;

   function automatic logic [2:0] clamp_pre(input logic [2:0] p);
      if (p == 3'd0)      return 3'd1;
      else if (p > 3'd4)  return 3'd4;
      else                return p;
   endfunction

   always_comb begin
      last_cnt = '0;
      case (state)
         S_PRE, S_INTER: last_cnt = CNT_W'(pre_q) - CNT_W'(1);
         S_DATA:         last_cnt = len_q - CNT_W'(1);
         S_POST:         last_cnt = CNT_W'(post_q) - CNT_W'(1);
         default:        last_cnt = '0;
      endcase
   end

   // The end-of-burst decision also honours a request arriving on the final data/CRC cycle.
   assign state_last  = (cnt == last_cnt);
   assign start       = (state == S_IDLE) && (i_rd_en || pending);
   assign burst_end   = ((state == S_DATA) && state_last && !crc_q) || (state == S_CRC);
   assign after_state = (pending || i_rd_en) ? S_INTER :
                        (post_q == 2'd0)     ? S_IDLE  : S_POST;
   assign take_inter  = burst_end && (after_state == S_INTER);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         pending  <= 1'b0;
         overflow <= 1'b0;
         pre_q    <= 3'd0;
         post_q   <= 2'd0;
         len_q    <= '0;
         crc_q    <= 1'b0;
      end else begin
         if (state != S_IDLE && i_rd_en) begin
            if (pending) overflow <= 1'b1;
            else         pending  <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (start) state <= S_PRE;
            end
            S_PRE, S_INTER: begin
               if (state_last) begin
                  state <= S_DATA;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (state_last) begin
                  cnt   <= '0;
                  state <= crc_q ? S_CRC : after_state;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_CRC: begin
               cnt   <= '0;
               state <= after_state;
            end
            S_POST: begin
               if (state_last) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase

         // NOTE: with non-blocking assignments the last one in the block wins, so these
         // override the generic pending update above when a request is consumed.
         if (start) pending <= i_rd_en && pending;
         if (take_inter) pending <= 1'b0;

         if (start || take_inter) begin
            pre_q  <= clamp_pre(i_precycle);
            post_q <= i_postcycle;
            len_q  <= (i_burstlength == 2'b01) ? CNT_W'(BL8_CYCLES) : CNT_W'(BL16_CYCLES);
            crc_q  <= i_dram_crc_en && CRC_ON;
         end
      end
   end

   assign o_state      = state;
   assign o_dqs_gate   = (state != S_IDLE);
   assign o_capture_en = (state == S_DATA);
   assign o_beat_cnt   = (state == S_DATA) ? cnt : '0;
   assign o_burst_done = burst_end;
   assign o_overflow   = overflow;
`ifdef RD_CRC_CHECK_EN
   assign o_crc_check  = (state == S_CRC);
`else
   assign o_crc_check  = 1'b0;
`endif

endmodule
